// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: load/store bus sequencing and write-back record generation
//
// Purpose:
//   Takes the EX-stage ALU result either as a load/store effective address or as a
//   pass-through value. Runs LW/LB/LBU/SW/SB on a req/ack data bus, holding EX off
//   while a transaction is outstanding, and emits one write-back pulse per accepted
//   instruction.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   ex_valid/ex_ready EX handshake; ex_ready is high iff the FSM is IDLE
//   mem_en, mem_op    access select and opcode (000 LW, 001 LB, 010 LBU, 100 SW, 101 SB)
//   alu_res           ALU result (effective address when mem_en=1)
//   store_data        store source register value
//   dst_reg, reg_we   destination register and its write request
//   bus_*             data-memory request channel, fields held stable until bus_ack
//   wb_*              write-back record, wb_valid is a one-cycle pulse
//   exc_misaligned    pulses with wb_valid for a misaligned or illegal access

module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              mem_en,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [ADDR_W-1:0] store_data,
  input  logic [4:0]        dst_reg,
  input  logic              reg_we,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [ADDR_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_data,
  output logic [4:0]        wb_reg,
  output logic              wb_we,
  output logic              exc_misaligned
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  typedef enum logic {IDLE, BUS} state_t;

  state_t state, state_n;

  // Instruction context kept for the duration of a bus transaction.
  logic [2:0]        op_q, op_n;
  logic [1:0]        lane_q, lane_n;
  logic              we_q, we_n;
  logic [4:0]        dst_q, dst_n;

  logic              bus_req_n, bus_we_n;
  logic [ADDR_W-1:0] bus_addr_n, bus_wdata_n;
  logic [3:0]        bus_be_n;
  logic              wb_valid_n, wb_we_n, exc_n;
  logic [ADDR_W-1:0] wb_data_n;
  logic [4:0]        wb_reg_n;

  logic              op_legal, op_misaligned;
  logic [7:0]        lane_byte;
  logic [ADDR_W-1:0] load_data;

  assign ex_ready = (state == IDLE);

  assign op_legal = (mem_op == OP_LW) || (mem_op == OP_LB) || (mem_op == OP_LBU) ||
                    (mem_op == OP_SW) || (mem_op == OP_SB);
  // Only word accesses carry an alignment requirement; byte accesses are legal anywhere.
  assign op_misaligned = ((mem_op == OP_LW) || (mem_op == OP_SW)) && (alu_res[1:0] != 2'b00);

  // Byte loads always fetch the full word; the addressed lane is picked here on return.
  always_comb begin
    lane_byte = bus_rdata[8*lane_q +: 8];
    case (op_q)
      OP_LB:   load_data = {{(ADDR_W-8){lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {{(ADDR_W-8){1'b0}}, lane_byte};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_n     = state;
    op_n        = op_q;
    lane_n      = lane_q;
    we_n        = we_q;
    dst_n       = dst_q;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_be_n    = bus_be;
    bus_wdata_n = bus_wdata;
    wb_valid_n  = 1'b0;
    wb_we_n     = 1'b0;
    exc_n       = 1'b0;
    wb_data_n   = wb_data;
    wb_reg_n    = wb_reg;

    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!mem_en) begin
            wb_valid_n = 1'b1;
            wb_data_n  = alu_res;
            wb_reg_n   = dst_reg;
            wb_we_n    = reg_we && (dst_reg != 5'd0);
          end else if (!op_legal || op_misaligned) begin
            wb_valid_n = 1'b1;
            wb_data_n  = '0;
            wb_reg_n   = dst_reg;
            exc_n      = 1'b1;
          end else begin
            state_n     = BUS;
            op_n        = mem_op;
            lane_n      = alu_res[1:0];
            we_n        = reg_we;
            dst_n       = dst_reg;
            bus_req_n   = 1'b1;
            bus_we_n    = mem_op[2];
            bus_addr_n  = {alu_res[ADDR_W-1:2], 2'b00};
            bus_be_n    = (mem_op == OP_SB) ? (4'b0001 << alu_res[1:0]) : 4'b1111;
            if (mem_op == OP_SB)
              bus_wdata_n = {4{store_data[7:0]}};
            else if (mem_op == OP_SW)
              bus_wdata_n = store_data;
            else
              bus_wdata_n = '0;
          end
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_n    = IDLE;
          bus_req_n  = 1'b0;
          wb_valid_n = 1'b1;
          wb_reg_n   = dst_q;
          if (op_q[2]) begin
            wb_data_n = '0;
          end else begin
            wb_data_n = load_data;
            wb_we_n   = we_q && (dst_q != 5'd0);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_q           <= 3'b000;
      lane_q         <= 2'b00;
      we_q           <= 1'b0;
      dst_q          <= 5'd0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_be         <= 4'b0000;
      bus_wdata      <= '0;
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      wb_reg         <= 5'd0;
      wb_we          <= 1'b0;
      exc_misaligned <= 1'b0;
    end else begin
      state          <= state_n;
      op_q           <= op_n;
      lane_q         <= lane_n;
      we_q           <= we_n;
      dst_q          <= dst_n;
      bus_req        <= bus_req_n;
      bus_we         <= bus_we_n;
      bus_addr       <= bus_addr_n;
      bus_be         <= bus_be_n;
      bus_wdata      <= bus_wdata_n;
      wb_valid       <= wb_valid_n;
      wb_data        <= wb_data_n;
      wb_reg         <= wb_reg_n;
      wb_we          <= wb_we_n;
      exc_misaligned <= exc_n;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, mem_en, reg_we;
  logic [2:0]  mem_op;
  logic [31:0] alu_res, store_data;
  logic [4:0]  dst_reg;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        wb_valid, wb_we, exc_misaligned;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_en(mem_en), .mem_op(mem_op), .alu_res(alu_res), .store_data(store_data),
    .dst_reg(dst_reg), .reg_we(reg_we), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_we(wb_we), .exc_misaligned(exc_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        mem_en;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic        rwe;
    int          waitn;
    logic [31:0] rdata;
    logic        e_bus;
    logic        e_bus_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_we;
    logic        e_exc;
  } vec_t;

  function automatic vec_t mk(input logic me, input logic [2:0] op, input logic [31:0] alu,
                              input logic [31:0] sd, input logic [4:0] dst, input logic rwe,
                              input int waitn, input logic [31:0] rdata, input logic e_bus,
                              input logic [3:0] e_be, input logic [31:0] e_wdata,
                              input logic [31:0] e_data, input logic e_we, input logic e_exc);
    vec_t v;
    v.mem_en = me; v.op = op; v.alu = alu; v.sd = sd; v.dst = dst; v.rwe = rwe;
    v.waitn = waitn; v.rdata = rdata; v.e_bus = e_bus; v.e_bus_we = e_bus && op[2];
    v.e_be = e_be; v.e_wdata = e_wdata; v.e_data = e_data; v.e_we = e_we; v.e_exc = e_exc;
    return v;
  endfunction

  // Reference: derive the expected outcome from the instruction rules with plain arithmetic.
  function automatic vec_t model(input vec_t v);
    int  k;
    int  b;
    bit  legal;
    vec_t r;
    r = v;
    k = int'(v.alu[1:0]);
    legal = (v.op == 0) || (v.op == 1) || (v.op == 2) || (v.op == 4) || (v.op == 5);
    r.e_bus = 0; r.e_bus_we = 0; r.e_be = 4'hf; r.e_wdata = 0;
    r.e_data = 0; r.e_we = 0; r.e_exc = 0;
    if (!v.mem_en) begin
      r.e_data = v.alu;
      r.e_we   = v.rwe && (v.dst != 0);
    end else if (!legal || ((v.op == 0 || v.op == 4) && k != 0)) begin
      r.e_exc = 1;
    end else begin
      r.e_bus    = 1;
      r.e_bus_we = (v.op >= 4);
      if (v.op == 5) begin
        r.e_be    = 4'(1 << k);
        r.e_wdata = 32'(v.sd[7:0]) * 32'h0101_0101;
      end else if (v.op == 4) begin
        r.e_wdata = v.sd;
      end
      if (v.op < 4) begin
        b = int'((v.rdata >> (8 * k)) & 32'hff);
        if (v.op == 0)      r.e_data = v.rdata;
        else if (v.op == 1) r.e_data = (b >= 128) ? 32'(b - 256) : 32'(b);
        else                r.e_data = 32'(b);
        r.e_we = v.rwe && (v.dst != 0);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s/%s: got %h expected %h", tag, nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1; issues one instruction and serves its bus transaction.
  task automatic run_op(input vec_t v, input string tag);
    chk(tag, "ready_at_issue", ex_ready, 1);
    ex_valid = 1; mem_en = v.mem_en; mem_op = v.op; alu_res = v.alu;
    store_data = v.sd; dst_reg = v.dst; reg_we = v.rwe;
    @(posedge clk); #1;
    ex_valid = 0;
    if (v.e_bus) begin
      chk(tag, "bus_req", bus_req, 1);
      chk(tag, "bus_we", bus_we, v.e_bus_we);
      chk(tag, "bus_addr", bus_addr, {v.alu[31:2], 2'b00});
      chk(tag, "bus_be", bus_be, v.e_be);
      if (v.e_bus_we) chk(tag, "bus_wdata", bus_wdata, v.e_wdata);
      chk(tag, "wb_valid_early", wb_valid, 0);
      for (int i = 0; i <= v.waitn; i++) begin
        // Junk on the EX side must be ignored while the transaction is open.
        ex_valid = 1; mem_en = 1'b0; alu_res = $urandom; dst_reg = 5'd1; reg_we = 1'b1;
        bus_ack = (i == v.waitn);
        bus_rdata = (i == v.waitn) ? v.rdata : $urandom;
        chk(tag, "ready_in_bus", ex_ready, 0);
        @(posedge clk); #1;
        if (i < v.waitn) begin
          chk(tag, "req_held", bus_req, 1);
          chk(tag, "addr_held", bus_addr, {v.alu[31:2], 2'b00});
          chk(tag, "wb_valid_wait", wb_valid, 0);
        end
      end
      bus_ack = 0; ex_valid = 0;
    end
    chk(tag, "bus_req_done", bus_req, 0);
    chk(tag, "wb_valid", wb_valid, 1);
    chk(tag, "wb_reg", wb_reg, v.dst);
    chk(tag, "wb_we", wb_we, v.e_we);
    chk(tag, "exc", exc_misaligned, v.e_exc);
    if (!v.e_exc) chk(tag, "wb_data", wb_data, v.e_data);
    chk(tag, "ready_after", ex_ready, 1);
  endtask

  vec_t tbl[15];
  vec_t v;

  initial begin
    rst = 1; ex_valid = 0; mem_en = 0; mem_op = 0; alu_res = 0; store_data = 0;
    dst_reg = 0; reg_we = 0; bus_ack = 0; bus_rdata = 0;

    tbl[0]  = mk(0, 3'd0, 32'h11, 0, 5'd5, 1, 0, 0, 0, 4'hf, 0, 32'h11, 1, 0);
    tbl[1]  = mk(0, 3'd0, 32'h22, 0, 5'd5, 1, 0, 0, 0, 4'hf, 0, 32'h22, 1, 0);
    tbl[2]  = mk(0, 3'd0, 32'h33, 0, 5'd5, 1, 0, 0, 0, 4'hf, 0, 32'h33, 1, 0);
    tbl[3]  = mk(1, 3'd0, 32'h1000_0004, 0, 5'd8, 1, 3, 32'hDEAD_BEEF, 1, 4'hf, 0, 32'hDEAD_BEEF, 1, 0);
    tbl[4]  = mk(1, 3'd1, 32'h1000_0006, 0, 5'd9, 1, 1, 32'h0080_0000, 1, 4'hf, 0, 32'hFFFF_FF80, 1, 0);
    tbl[5]  = mk(1, 3'd2, 32'h1000_0006, 0, 5'd10, 1, 0, 32'h0080_0000, 1, 4'hf, 0, 32'h0000_0080, 1, 0);
    tbl[6]  = mk(1, 3'd5, 32'h1000_0003, 32'h1234_5678, 5'd11, 1, 2, 0, 1, 4'b1000, 32'h7878_7878, 0, 0, 0);
    tbl[7]  = mk(1, 3'd0, 32'h1000_0002, 0, 5'd12, 1, 0, 0, 0, 4'hf, 0, 0, 0, 1);
    tbl[8]  = mk(0, 3'd0, 32'h55, 0, 5'd0, 1, 0, 0, 0, 4'hf, 0, 32'h55, 0, 0);
    tbl[9]  = mk(1, 3'd3, 32'h2000_0000, 0, 5'd4, 1, 0, 0, 0, 4'hf, 0, 0, 0, 1);
    tbl[10] = mk(1, 3'd4, 32'h2000_0008, 32'hCAFE_F00D, 5'd3, 1, 0, 0, 1, 4'hf, 32'hCAFE_F00D, 0, 0, 0);
    tbl[11] = mk(1, 3'd1, 32'h2000_0007, 0, 5'd6, 1, 1, 32'h7F00_0000, 1, 4'hf, 0, 32'h0000_007F, 1, 0);
    tbl[12] = mk(1, 3'd0, 32'h0000_0040, 0, 5'd0, 1, 0, 32'h1234_5678, 1, 4'hf, 0, 32'h1234_5678, 0, 0);
    tbl[13] = mk(1, 3'd4, 32'h2000_0001, 32'h1, 5'd2, 1, 0, 0, 0, 4'hf, 0, 0, 0, 1);
    tbl[14] = mk(1, 3'd5, 32'h3000_0000, 32'h0000_00AB, 5'd7, 1, 1, 0, 1, 4'b0001, 32'hABAB_ABAB, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "bus_req", bus_req, 0);
    chk("reset", "bus_addr", bus_addr, 0);
    chk("reset", "bus_be", bus_be, 0);
    chk("reset", "wb_valid", wb_valid, 0);
    chk("reset", "wb_data", wb_data, 0);
    chk("reset", "exc", exc_misaligned, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("reset", "ready", ex_ready, 1);

    for (int i = 0; i < 15; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // wb_valid is a single-cycle pulse; bus_ack is ignored while idle
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("idle", "wb_valid_pulse", wb_valid, 0);
    chk("idle", "exc_pulse", exc_misaligned, 0);
    chk("idle", "no_req", bus_req, 0);
    chk("idle", "ready", ex_ready, 1);
    bus_ack = 0;

    // Reset in the middle of a bus wait abandons the transaction
    ex_valid = 1; mem_en = 1; mem_op = 3'd0; alu_res = 32'h3000_0010; dst_reg = 5'd7; reg_we = 1;
    @(posedge clk); #1;
    ex_valid = 0;
    chk("rstbus", "req_open", bus_req, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rstbus", "req_waiting", bus_req, 1);
    rst = 1;
    #1;
    chk("rstbus", "req_drop", bus_req, 0);
    chk("rstbus", "wb_valid_rst", wb_valid, 0);
    bus_ack = 1;
    repeat (2) @(posedge clk);
    #1;
    bus_ack = 0;
    rst = 0;
    chk("rstbus", "wb_valid_held", wb_valid, 0);
    @(posedge clk); #1;
    chk("rstbus", "wb_valid_after", wb_valid, 0);
    chk("rstbus", "ready_after", ex_ready, 1);
    run_op(mk(1, 3'd0, 32'h3000_0010, 0, 5'd7, 1, 1, 32'h0BAD_F00D, 1, 4'hf, 0, 32'h0BAD_F00D, 1, 0), "rstbus_lw");

    // Randomized instructions against the reference model
    for (int n = 0; n < 80; n++) begin
      v.mem_en = ($urandom_range(0, 3) != 0);
      v.op     = 3'($urandom_range(0, 7));
      v.alu    = $urandom;
      v.sd     = $urandom;
      v.dst    = 5'($urandom_range(0, 31));
      v.rwe    = 1'($urandom_range(0, 1));
      v.waitn  = $urandom_range(0, 3);
      v.rdata  = $urandom;
      v = model(v);
      run_op(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk($sformatf("rnd%0d", n), "gap_wb_valid", wb_valid, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the MIPS pipeline, directly downstream of the EX-stage ALU.
- Consumes the ALU result either as a load/store effective address or as a pass-through result.
- Runs LW/LB/LBU/SW/SB transactions on a req/ack data-memory bus and produces one write-back record per accepted instruction.
- Stalls EX (ex_ready low) while a bus transaction is outstanding.

Parameters:
ADDR_W, 32, width of ALU result, bus address and data paths (only 32 supported)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  EX presents an instruction this cycle
ex_ready  out  1  stage can accept; combinational, high iff state==IDLE
mem_en  in  1  1 = load/store, 0 = pass alu_res through
mem_op  in  3  000 LW, 001 LB, 010 LBU, 100 SW, 101 SB; others illegal
alu_res  in  32  ALU output (address when mem_en=1)
store_data  in  32  rt value for stores
dst_reg  in  5  destination register
reg_we  in  1  instruction writes a register
bus_req  out  1  data-memory request
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
bus_be  out  4  byte enables, little-endian
bus_wdata  out  32  write data
bus_ack  in  1  memory completes current request this cycle
bus_rdata  in  32  read data, valid when bus_ack=1
wb_valid  out  1  one-cycle pulse: write-back record valid
wb_data  out  32  result to register file
wb_reg  out  5  destination register
wb_we  out  1  register write enable
exc_misaligned  out  1  one-cycle pulse with wb_valid for misaligned/illegal access

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - bus_req, bus_we, wb_valid, wb_we and exc_misaligned go to 0.
  - bus_addr, bus_be, bus_wdata, wb_data and wb_reg go to 0.
  - ex_ready becomes 1 once rst deasserts.
  - Reset mid-BUS abandons the transaction: bus_req drops immediately and no wb record is produced.
- FSM states: IDLE, BUS.
- Each cycle with ex_valid && ex_ready, IDLE captures all inputs. Outcome by case:
  - mem_en=0: next cycle wb_valid=1, wb_data=alu_res, wb_reg=dst_reg, wb_we=reg_we. Stay in IDLE; back-to-back acceptance every cycle.
  - Illegal mem_op, or LW/SW with addr[1:0]!=0: no bus activity. Next cycle wb_valid=1, wb_we=0, exc_misaligned=1. Stay in IDLE.
  - Legal access: next cycle enter BUS with bus_req=1 and bus_addr/bus_we/bus_be/bus_wdata registered.
- BUS:
  - bus_req and the request fields are held stable until bus_ack is sampled high.
  - ex_ready=0 throughout.
  - On the ack edge: return to IDLE, and the next cycle has wb_valid=1 with bus_req=0.
  - Minimum memory-op latency: accept at cycle N, bus_req at N+1, ack at N+1, wb_valid at N+2.
  - Each extra wait cycle of ack adds one cycle.
- Byte lanes (addr[1:0]=k):
  - LW/SW: be=4'b1111.
  - LB/LBU: be=4'b1111 (read full word).
  - SB: be=1<<k, wdata=store_data[7:0] replicated in all four lanes.
  - SW: wdata=store_data.
- Load data:
  - LW: bus_rdata.
  - LB: sign-extend bus_rdata[8k+7:8k].
  - LBU: zero-extend bus_rdata[8k+7:8k].
- Write enable:
  - Stores: wb_we=0, wb_data=0.
  - Loads: wb_we=reg_we.
  - wb_we is forced to 0 whenever wb_reg==0, for every path.
- bus_ack is ignored in IDLE.
- No back-pressure from write-back; wb_valid is a pulse.
- ex_valid is ignored in BUS.

Test Plan:
- Pass-through: 3 back-to-back ops with alu_res 0x11, 0x22, 0x33 to r5 -> wb_valid high 3 consecutive cycles with wb_data 0x11, 0x22, 0x33; ex_ready stays 1.
- LW at 0x1000_0004, ack after 3 wait cycles, rdata 0xDEADBEEF -> bus_addr 0x1000_0004, be 1111; wb_data 0xDEADBEEF exactly 1 cycle after ack; ex_ready low from accept+1 to the ack cycle inclusive.
- LB/LBU at 0x...06, rdata 0x0080_0000 -> LB wb_data 0xFFFFFF80; LBU wb_data 0x00000080.
- SB at 0x...03, store_data 0x12345678 -> bus_we=1, be=1000, wdata 0x78787878, wb_we=0.
- LW at 0x...02 -> no bus_req ever; next cycle wb_valid=1, exc_misaligned=1, wb_we=0; op to dst_reg 0 with reg_we=1 -> wb_we=0.
- rst asserted 2 cycles into a BUS wait -> bus_req 0 immediately; no wb_valid; after release ex_ready=1 and a new LW completes normally.
